// File: rtl/uart_axi_pkg.sv
// Shared types for the UART-AXI4 bridge receive path: SOF marker, parser states, CMD layout, error codes.
// No logic; constants and one helper that turns a CMD into its payload length.
// Imported by frame_parser and its payload buffer.
package uart_axi_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CRC,
    ST_HOLD,
    ST_ERR
  } parser_state_t;

  // CMD byte: [7]=RW (1=read), [6] unused, [5:4]=size, [3:0]=beats-1
  typedef struct packed {
    logic       rw;
    logic       rsvd;
    logic [1:0] size;
    logic [3:0] beats_m1;
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CRC     = 2'd1,
    ERR_SIZE    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  // size field is a left-shift amount on the beat count
  localparam logic [1:0] SZ_8    = 2'd0;
  localparam logic [1:0] SZ_16   = 2'd1;
  localparam logic [1:0] SZ_32   = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // Bytes carried by a write frame with this CMD (max 16 beats x 4 bytes = 64)
  function automatic logic [7:0] payload_bytes(input cmd_t c);
    logic [7:0] n;
    n = (8'(c.beats_m1) + 8'd1) << c.size;
    return n;
  endfunction

endpackage

// File: rtl/frame_parser_if.sv
// Bundles the frame parser's byte stream, CRC side-channel, frame handoff, buffer read and error signals.
// Pure wiring, no latency.
// master = parser side, slave = the surrounding UART/CRC/AXI environment.
interface frame_parser_if #(
  parameter int AW = 6
);
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        crc_enable;
  logic [7:0]  crc_data;
  logic        crc_reset;
  logic [7:0]  crc_value;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  frame_cmd;
  logic [31:0] frame_addr;
  logic [AW:0] frame_len;
  logic [AW-1:0] buf_rd_addr;
  logic [7:0]  buf_rd_data;
  logic        err_valid;
  logic [1:0]  err_code;

  modport master (
    input  rx_data, rx_valid, crc_value, frame_ready, buf_rd_addr,
    output rx_ready, crc_enable, crc_data, crc_reset, frame_valid,
           frame_cmd, frame_addr, frame_len, buf_rd_data, err_valid, err_code
  );

  modport slave (
    output rx_data, rx_valid, crc_value, frame_ready, buf_rd_addr,
    input  rx_ready, crc_enable, crc_data, crc_reset, frame_valid,
           frame_cmd, frame_addr, frame_len, buf_rd_data, err_valid, err_code
  );

endinterface

// File: rtl/frame_payload_buf.sv
// Write-payload byte RAM: one write port, one synchronous read port.
// Latency: read data appears one clock after rd_addr.
// No backpressure; a write happens every cycle wr_en is high.
module frame_payload_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // storage array, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read port, cleared in reset so the output starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_parser.sv
// UART RX command framer: finds SOF, feeds CMD/ADDR/DATA to CRC8, checks the CRC byte, hands (cmd, addr, payload) on.
// Latency: frame_valid rises the cycle after the CRC byte is accepted; buffer reads take one cycle.
// Backpressure: rx_ready drops while a frame is held for the consumer or an error is reported. Option: FRAME_PARSER_TIMEOUT_EN.
module frame_parser
  import uart_axi_pkg::*;
#(
  parameter int         MAX_PAYLOAD_BYTES = 64,
  parameter logic [7:0] SOF_BYTE          = SOF,
  parameter int         TIMEOUT_CYCLES    = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_parser_if.master bus
);

  localparam int         AW        = $clog2(MAX_PAYLOAD_BYTES);
  localparam logic [7:0] MAX_BYTES = 8'(MAX_PAYLOAD_BYTES);

  parser_state_t state;
  logic          rx_ready_q;
  logic          frame_valid_q;
  logic          err_valid_q;
  err_code_t     err_code_q;
  cmd_t          cmd_q;
  logic [31:0]   addr_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] count;

  logic          accept;
  logic          sof_accept;
  logic          crc_byte;
  cmd_t          cmd_in;
  logic [7:0]    pay_bytes;
  logic          bad_cmd;
  logic          last_data;
  logic          buf_wr;
  logic          tmo_hit;

  assign accept     = bus.rx_valid && rx_ready_q;
  assign sof_accept = accept && (state == ST_IDLE) && (bus.rx_data == SOF_BYTE);
  assign crc_byte   = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign cmd_in     = cmd_t'(bus.rx_data);
  assign pay_bytes  = payload_bytes(cmd_in);
  assign bad_cmd    = (cmd_in.size == SZ_RSVD) || (pay_bytes > MAX_BYTES);
  assign last_data  = ({1'b0, count} == (len_q - 1'b1));
  assign buf_wr     = accept && (state == ST_DATA);

`ifdef FRAME_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = crc_byte || (state == ST_CRC);
  assign tmo_hit  = in_frame && !accept && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // inter-byte idle counter, only meaningful while a frame is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt <= '0;
    else if (!in_frame || accept) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // CRC calculator is driven straight from the accepted byte so it folds in the same cycle
  assign bus.crc_enable = accept && crc_byte;
  assign bus.crc_data   = bus.rx_data;
  assign bus.crc_reset  = !rst_n || sof_accept;

  assign bus.rx_ready    = rx_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cmd   = cmd_q;
  assign bus.frame_addr  = addr_q;
  assign bus.frame_len   = len_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_code    = err_code_q;

  frame_payload_buf #(
    .DEPTH (MAX_PAYLOAD_BYTES),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_addr (count),
    .wr_data (bus.rx_data),
    .rd_addr (bus.buf_rd_addr),
    .rd_data (bus.buf_rd_data)
  );

  // frame state machine with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rx_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      cmd_q         <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      count         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rx_ready_q <= 1'b1;
          if (sof_accept) state <= ST_CMD;
        end

        ST_CMD: begin
          if (accept) begin
            cmd_q <= cmd_in;
            len_q <= cmd_in.rw ? '0 : pay_bytes[AW:0];
            count <= '0;
            if (bad_cmd) begin
              state       <= ST_ERR;
              rx_ready_q  <= 1'b0;
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_SIZE;
            end else begin
              state <= ST_ADDR;
            end
          end
        end

        ST_ADDR: begin
          if (accept) begin
            addr_q[{count[1:0], 3'b000} +: 8] <= bus.rx_data;
            if (count == AW'(3)) begin
              count <= '0;
              state <= cmd_q.rw ? ST_CRC : ST_DATA;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
            if (last_data) state <= ST_CRC;
            else           count <= count + 1'b1;
          end
        end

        ST_CRC: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == bus.crc_value) begin
              state         <= ST_HOLD;
              frame_valid_q <= 1'b1;
            end else begin
              state       <= ST_ERR;
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_CRC;
            end
          end
        end

        ST_HOLD: begin
          if (bus.frame_ready) begin
            state         <= ST_IDLE;
            frame_valid_q <= 1'b0;
            rx_ready_q    <= 1'b1;
          end
        end

        ST_ERR: begin
          state       <= ST_IDLE;
          err_valid_q <= 1'b0;
          err_code_q  <= ERR_NONE;
          rx_ready_q  <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase

      // idle line mid-frame abandons the frame
      if (tmo_hit) begin
        state       <= ST_ERR;
        rx_ready_q  <= 1'b0;
        err_valid_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
// Scoreboard bench for frame_parser with a behavioural CRC8 (poly 0x07, init 0x00) on the CRC side-channel.
// Expected frames/errors are queued when a frame is sent and popped when the DUT presents a result.
// Define FRAME_PARSER_TIMEOUT_EN to also exercise the inter-byte timeout (TIMEOUT_CYCLES=50).
module tb_frame_parser;
  import uart_axi_pkg::*;

  localparam int MAXP = 64;
  localparam int AW   = 6;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [6:0]  len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_parser_if #(.AW(AW)) bus ();

  frame_parser #(
    .MAX_PAYLOAD_BYTES (MAXP),
    .SOF_BYTE          (8'hA5),
    .TIMEOUT_CYCLES    (50)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // behavioural CRC8 calculator sitting on the side-channel
  logic [7:0] crc_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              crc_q <= 8'h00;
    else if (bus.crc_reset)  crc_q <= 8'h00;
    else if (bus.crc_enable) crc_q <= crc8(crc_q, bus.crc_data);
  end
  assign bus.crc_value = crc_q;

  int crc_en_cnt = 0;
  always @(posedge clk) if (bus.crc_enable) crc_en_cnt <= crc_en_cnt + 1;

  int n_checks = 0;
  int n_err    = 0;
  int crc_snap;
  exp_t       exp_q[$];
  logic [7:0] exp_data[$];
  logic [7:0] pay[MAXP];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // present one byte from a negedge and hold it until the DUT takes it
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rx_stall", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic corrupt);
    exp_t       e;
    logic [7:0] crc;
    int         plen;
    plen = cmd[7] ? 0 : ((int'(cmd[3:0]) + 1) << cmd[5:4]);
    e.is_err = corrupt;
    e.code   = corrupt ? 2'd1 : 2'd0;
    e.cmd    = cmd;
    e.addr   = addr;
    e.len    = 7'(plen);
    exp_q.push_back(e);
    if (!corrupt) for (int i = 0; i < plen; i++) exp_data.push_back(pay[i]);
    crc_snap = crc_en_cnt;
    send_byte(8'hA5);
    crc = 8'h00;
    send_byte(cmd);
    crc = crc8(crc, cmd);
    for (int i = 0; i < 4; i++) begin
      send_byte(addr[8*i +: 8]);
      crc = crc8(crc, addr[8*i +: 8]);
    end
    for (int i = 0; i < plen; i++) begin
      send_byte(pay[i]);
      crc = crc8(crc, pay[i]);
    end
    send_byte(crc ^ {7'd0, corrupt});
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  // pop the next expectation and compare it with what the DUT presents
  task automatic wait_result(input int hold_cycles, output int waited);
    exp_t e;
    int   n;
    e = exp_q.pop_front();
    n = 0;
    while (!(bus.frame_valid || bus.err_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (n >= 200) check("result_wait", 32'(bus.frame_valid | bus.err_valid), 32'd1);
    if (e.is_err) begin
      check("err_valid", 32'(bus.err_valid), 32'd1);
      check("err_code", 32'(bus.err_code), 32'(e.code));
      check("err_no_frame", 32'(bus.frame_valid), 32'd0);
      check("err_rdy", 32'(bus.rx_ready), 32'd0);
      @(negedge clk);
      check("err_pulse", 32'(bus.err_valid), 32'd0);
      check("err_rdy_back", 32'(bus.rx_ready), 32'd1);
    end else begin
      check("frame_cmd", 32'(bus.frame_cmd), 32'(e.cmd));
      check("frame_addr", bus.frame_addr, e.addr);
      check("frame_len", 32'(bus.frame_len), 32'(e.len));
      check("crc_en_cnt", 32'(crc_en_cnt - crc_snap), 32'(5 + int'(e.len)));
      bus.rx_data  = 8'hA5;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < hold_cycles; i++) begin
        @(negedge clk);
        check("hold_rdy", 32'(bus.rx_ready), 32'd0);
        check("hold_vld", 32'(bus.frame_valid), 32'd1);
        check("hold_addr", bus.frame_addr, e.addr);
        check("hold_cmd", 32'(bus.frame_cmd), 32'(e.cmd));
        check("hold_crc_en", 32'(bus.crc_enable), 32'd0);
      end
      bus.rx_valid = 1'b0;
      for (int i = 0; i < int'(e.len); i++) begin
        bus.buf_rd_addr = AW'(i);
        @(negedge clk);
        check("buf_data", 32'(bus.buf_rd_data), 32'(exp_data.pop_front()));
      end
      bus.frame_ready = 1'b1;
      @(negedge clk);
      bus.frame_ready = 1'b0;
      check("hold_exit", 32'(bus.frame_valid), 32'd0);
      check("turn_rdy", 32'(bus.rx_ready), 32'd1);
    end
  endtask

  int waited;

  initial begin
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.frame_ready = 1'b0;
    bus.buf_rd_addr = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(bus.rx_ready), 32'd0);
    check("rst_crc_reset", 32'(bus.crc_reset), 32'd1);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_err_valid", 32'(bus.err_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("deassert_rdy", 32'(bus.rx_ready), 32'd0);
    check("deassert_crc_reset", 32'(bus.crc_reset), 32'd0);
    @(negedge clk);
    check("idle_rdy", 32'(bus.rx_ready), 32'd1);

    // plain read, then the same frame with a bad CRC byte
    send_frame(8'h80, 32'h0000_0000, 1'b0);
    wait_result(2, waited);
    send_frame(8'h80, 32'h0000_0000, 1'b1);
    wait_result(0, waited);

    // 32-bit x 2 beat write
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    send_frame(8'h21, 32'h4000_0010, 1'b0);
    wait_result(3, waited);

    // leading garbage is swallowed without touching the CRC
    crc_snap = crc_en_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    check("garbage_crc_en", 32'(crc_en_cnt - crc_snap), 32'd0);
    check("garbage_frame", 32'(bus.frame_valid | bus.err_valid), 32'd0);
    send_frame(8'h80, 32'h1234_5678, 1'b0);
    wait_result(10, waited);

    // smallest write then largest write, back to back
    pay[0] = 8'hA5;
    send_frame(8'h00, 32'hDEAD_BEEF, 1'b0);
    wait_result(1, waited);
    for (int i = 0; i < MAXP; i++) pay[i] = 8'($urandom_range(0, 255));
    send_frame(8'h2F, 32'h0000_1000, 1'b0);
    wait_result(1, waited);

    // read with nonzero size/beats still has no payload
    send_frame(8'h93, 32'hCAFE_0004, 1'b0);
    wait_result(1, waited);

    // reserved size
    push_err(2'd2);
    send_byte(8'hA5);
    send_byte(8'h30);
    wait_result(0, waited);

    // reset in the middle of the address field
    send_byte(8'hA5);
    send_byte(8'h81);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(bus.rx_ready), 32'd0);
    check("midrst_crc_reset", 32'(bus.crc_reset), 32'd1);
    check("midrst_cmd", 32'(bus.frame_cmd), 32'd0);
    check("midrst_err", 32'(bus.err_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h80, 32'h0BAD_F00D, 1'b0);
    wait_result(1, waited);

`ifdef FRAME_PARSER_TIMEOUT_EN
    push_err(2'd3);
    send_byte(8'hA5);
    send_byte(8'h80);
    wait_result(0, waited);
    check("timeout_cycles", 32'(waited), 32'd50);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_parser.md
Name: frame_parser

Overview:
- Receive-side command framer for the UART-AXI4 bridge.
- Takes bytes from the UART RX byte stream, delimits frames and drives the CRC8 calculator byte-by-byte.
- Checks the trailing CRC byte, buffers write payload, and hands a decoded command (cmd, addr, payload) to the AXI4 master stage over a valid/ready handshake.

Parameters:
- MAX_PAYLOAD_BYTES, 64, payload buffer depth in bytes (power of 2, ≥16).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  parser accepts byte; transfer when rx_valid&&rx_ready
- crc_enable  out  1  fold crc_data into CRC this cycle
- crc_data  out  8  byte to CRC (equals rx_data)
- crc_reset  out  1  clear CRC to 0x00
- crc_value  in  8  registered CRC from CRC8 calculator (poly 0x07, init 0x00)
- frame_valid  out  1  decoded frame available
- frame_ready  in  1  consumer accepts frame
- frame_cmd  out  8  CMD byte: [7]=RW (1=read), [5:4]=size (0=8b, 1=16b, 2=32b, 3=reserved), [3:0]=beats-1
- frame_addr  out  32  address, little-endian assembled
- frame_len  out  7  payload bytes in buffer (0 for reads)
- buf_rd_addr  in  6  payload buffer read index ($clog2(MAX_PAYLOAD_BYTES))
- buf_rd_data  out  8  payload byte, 1-cycle read latency
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  1=CRC mismatch, 2=bad size/overflow, 3=timeout

Behaviour:
- Reset values:
  - state=IDLE
  - rx_ready=0 for the cycle of deassertion only, then 1 in IDLE
  - crc_reset=1 while in reset
  - all other outputs 0
- Frame format: SOF, CMD, ADDR0..ADDR3 (LSB first), DATA (writes only: (CMD[3:0]+1)<<CMD[5:4] bytes), CRC.
- CRC covers CMD through last DATA byte; the SOF is excluded.
- crc_enable=1 and crc_data=rx_data exactly on accepted CMD/ADDR/DATA bytes. Never on SOF or CRC bytes.
- States:
  - IDLE: rx_ready=1. Non-SOF bytes are discarded silently. SOF → CMD, with crc_reset pulsed that same cycle.
  - CMD: latch CMD. Size==3 or payload>MAX_PAYLOAD_BYTES → ERR (code 2). Otherwise → ADDR, byte count=0.
  - ADDR: 4 bytes, then → DATA (write) or → CRC (read).
  - DATA: write byte to buffer[count]; count wraps never (bounded by CMD check); after last byte → CRC.
  - CRC: compare rx_data with crc_value on acceptance. crc_value is valid because the CRC register updates the edge after the last enabled byte.
    - Match → HOLD.
    - Mismatch → ERR (code 1).
  - HOLD: frame_valid=1, rx_ready=0, fields stable. frame_valid&&frame_ready → IDLE next cycle.
  - ERR: err_valid=1 for one cycle, rx_ready=0, → IDLE; frame discarded.
- rx_ready=0 only in HOLD and ERR.
- The buffer is readable in HOLD; contents are undefined otherwise.
- Zero-latency turnaround: an SOF may be accepted in the cycle after HOLD exits.
- An SOF byte inside CMD/ADDR/DATA/CRC is treated as data, not a resync.
- frame_len = (CMD[3:0]+1)<<CMD[5:4] for writes, 0 for reads.
- Reset mid-frame: immediate return to IDLE, partial frame dropped, frame_valid and err_valid forced 0.

Optional Feature:
- FRAME_PARSER_TIMEOUT_EN:
  - When defined, a counter runs in CMD/ADDR/DATA/CRC and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES → ERR with code 3.
- When undefined, there is no counter, code 3 is never produced, and the parser waits indefinitely.

Decomposition:
- Shared package uart_axi_pkg holds:
  - SOF constant
  - parser state enum
  - CMD field struct (rw, size, beats_m1)
  - err_code enum
  - size→bytes shift constants
- One natural sub-module: frame_payload_buf, a single-port-write/single-port-read synchronous byte RAM of MAX_PAYLOAD_BYTES.

Test Plan:
- Read frame A5 80 00 00 00 00 97 → frame_valid=1, frame_cmd=0x80, frame_addr=0, frame_len=0, no err_valid.
- Same frame with CRC byte 0x96 → err_valid pulse with err_code=1, no frame_valid, next A5 accepted.
- Write frame A5 21 10 00 00 40 followed by 8 bytes 01..08 and the correct CRC (cmd size=16b, 2 beats... CMD=0x21 is 32b×2=8 bytes) → frame_len=8, frame_addr=0x40000010, buf_rd_data returns 01..08 at indices 0..7.
- Garbage 00 FF 12 then a valid read frame; frame_ready held low 10 cycles → garbage ignored, rx_ready=0 throughout HOLD, fields stable, exit on handshake.
- CMD=0x30 (reserved size) → err_code=2; rst_n asserted mid-ADDR → state IDLE, outputs at reset values.
- With FRAME_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=50: A5 80 then silence → err_code=3 after 50 cycles.
